mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-port arbiter and sequencer in front of the single DPI-backed data memory of the NPC core. It shares the memory between the instruction fetch unit (IFU, read-only) and the load/store unit (LSU, read/write). It accepts one request at a time with round-robin priority, drives the memory through a request/ready handshake, and waits for the read response with a timeout watchdog. It then returns the data to the owning requester as a one-cycle response pulse.

## Interface
- `AW`, 32: address width.
- `DW`, 32: data width.
- `TIMEOUT`, 255: maximum cycles spent in WAIT before an error response; must be ≥1.

Ports. Clock is `clock`; reset is `reset`, synchronous, active-high.
- `clock` in 1: clock.
- `reset` in 1: synchronous reset, active-high.
- `ifu_req_valid` in 1; `ifu_req_ready` out 1; `ifu_addr` in AW: IFU read request.
- `ifu_resp_valid` out 1; `ifu_resp_data` out DW; `ifu_resp_err` out 1: IFU response.
- `lsu_req_valid` in 1; `lsu_req_ready` out 1: LSU request handshake.
- `lsu_addr` in AW; `lsu_wen` in 1; `lsu_wdata` in DW; `lsu_wmask` in 8: LSU request payload.
- `lsu_resp_valid` out 1; `lsu_resp_data` out DW; `lsu_resp_err` out 1: LSU response.
- `mem_valid` out 1; `mem_ready` in 1: memory request handshake.
- `mem_wen` out 1; `mem_raddr` out AW; `mem_waddr` out AW; `mem_wdata` out DW; `mem_wmask` out 8: memory request payload.
- `mem_rvalid` in 1; `mem_rdata` in DW: memory response.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP. Reset state is IDLE.
- **IDLE:**
  - Computes the grant combinationally from the two `*_req_valid` inputs.
  - Asserts `*_req_ready` only for the granted requester, only in IDLE.
  - On handshake, registers owner, address, wen, wdata and wmask, then moves to ISSUE.
  - IFU requests are registered with wen=0, wmask=8'h0F and wdata=0.
- **Arbitration:**
  - Only one valid request: that requester wins.
  - Both valid: the requester not equal to `last_grant` wins.
  - `last_grant` updates on every accepted handshake; its reset value is LSU, so IFU wins the first tie.
- **ISSUE:**
  - Holds `mem_valid`=1 with the registered payload stable.
  - Drives `mem_raddr` and `mem_waddr` with the same registered address.
  - On `mem_ready`=1, moves to WAIT and clears the timeout counter.
- **WAIT:**
  - `mem_valid`=0; the counter increments each cycle.
  - On `mem_rvalid`=1: captures `mem_rdata`, sets err=0, moves to RESP.
  - If the counter reaches TIMEOUT without `mem_rvalid`: data=0, err=1, moves to RESP.
  - Writes also wait for `mem_rvalid`, which serves as the write ack; the captured data is returned unchanged.
- **RESP:**
  - Asserts the owner's `*_resp_valid` for exactly one cycle with the captured data and err, then returns to IDLE.
  - The non-owner's `*_resp_valid` stays 0.
  - Requesters must accept the response unconditionally; there is no response back-pressure.
- `mem_rvalid` outside WAIT is ignored and dropped. The memory must not return responses after a timeout; such late data is not attributed.
- **Reset values:**
  - All `*_req_ready`, `*_resp_valid`, `*_resp_err`, `mem_valid` and `mem_wen` = 0.
  - `*_resp_data`, `mem_*addr`, `mem_wdata` and `mem_wmask` = 0.
  - State = IDLE, counter = 0, `last_grant` = LSU.
- Reset in any state aborts the transaction in the next cycle: no response is produced and captured data is discarded.

## Timing
- Minimum latency, with `mem_ready` high in ISSUE and `mem_rvalid` in the first WAIT cycle:
  - Handshake at cycle T.
  - `mem_valid` at T+1.
  - `mem_rvalid` at T+2.
  - `*_resp_valid` at T+3.
  - Next request can be accepted at T+4.
- Each extra `mem_ready` stall cycle adds 1 cycle; each extra cycle in WAIT adds 1 cycle.
- Timeout path: `*_resp_valid`/err asserted TIMEOUT+1 cycles after the first WAIT cycle.
- `*_req_ready` is combinational from `*_req_valid` and state. All other outputs are registered.
- Requests arriving while busy are held by the requester; `*_req_ready` stays 0 until IDLE.

## Test plan
- **Single IFU read:** `ifu_addr`=0x80000000; memory returns 0x00000413 one cycle after `mem_ready`.
  - Expect `mem_wen`=0 and `mem_wmask`=0x0F at T+1.
  - Expect `ifu_resp_valid`=1 with data 0x00000413 and err=0 at T+3; `lsu_resp_valid` stays 0.
- **LSU write:** addr 0x80001000, wdata 0xDEADBEEF, wmask 0x0F, wen=1.
  - Expect `mem_valid`, `mem_wen`=1, and `mem_waddr`=`mem_raddr`=0x80001000 with stable payload across a 3-cycle `mem_ready` stall.
  - Expect one `lsu_resp_valid` pulse.
- **Contention:** both requesters valid continuously after reset.
  - Expect grants IFU, LSU, IFU, LSU; no back-to-back grant to the same requester.
- **Timeout:** TIMEOUT=4, `mem_rvalid` never asserted.
  - Expect `lsu_resp_err`=1 with data 0, 5 cycles after the first WAIT cycle; FSM back in IDLE the next cycle.
- **Stray response and mid-operation reset:**
  - `mem_rvalid` pulsed in IDLE: no response produced.
  - `reset` asserted in WAIT: next cycle all outputs 0, state IDLE; the later `mem_rvalid` is ignored.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the NPC requesters (IFU, LSU), the arbiter and the data memory.
// The slave view is the arbiter. The master view is the surrounding environment:
// the requesters plus the memory.
interface mem_arbiter_if #(
   parameter int AW = 32,
   parameter int DW = 32
);
   // IFU read port
   logic          ifu_req_valid;
   logic          ifu_req_ready;
   logic [AW-1:0] ifu_addr;
   logic          ifu_resp_valid;
   logic [DW-1:0] ifu_resp_data;
   logic          ifu_resp_err;

   // LSU read/write port
   logic          lsu_req_valid;
   logic          lsu_req_ready;
   logic [AW-1:0] lsu_addr;
   logic          lsu_wen;
   logic [DW-1:0] lsu_wdata;
   logic [7:0]    lsu_wmask;
   logic          lsu_resp_valid;
   logic [DW-1:0] lsu_resp_data;
   logic          lsu_resp_err;

   // memory side
   logic          mem_valid;
   logic          mem_ready;
   logic          mem_wen;
   logic [AW-1:0] mem_raddr;
   logic [AW-1:0] mem_waddr;
   logic [DW-1:0] mem_wdata;
   logic [7:0]    mem_wmask;
   logic          mem_rvalid;
   logic [DW-1:0] mem_rdata;

   modport slave (
      input  ifu_req_valid, ifu_addr,
      output ifu_req_ready, ifu_resp_valid, ifu_resp_data, ifu_resp_err,
      input  lsu_req_valid, lsu_addr, lsu_wen, lsu_wdata, lsu_wmask,
      output lsu_req_ready, lsu_resp_valid, lsu_resp_data, lsu_resp_err,
      output mem_valid, mem_wen, mem_raddr, mem_waddr, mem_wdata, mem_wmask,
      input  mem_ready, mem_rvalid, mem_rdata
   );

   modport master (
      output ifu_req_valid, ifu_addr,
      input  ifu_req_ready, ifu_resp_valid, ifu_resp_data, ifu_resp_err,
      output lsu_req_valid, lsu_addr, lsu_wen, lsu_wdata, lsu_wmask,
      input  lsu_req_ready, lsu_resp_valid, lsu_resp_data, lsu_resp_err,
      input  mem_valid, mem_wen, mem_raddr, mem_waddr, mem_wdata, mem_wmask,
      output mem_ready, mem_rvalid, mem_rdata
   );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter/sequencer that shares one data memory between the IFU and LSU.
// One transaction is in flight at a time: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
// A watchdog in WAIT turns a missing memory response into an error response.
module mem_arbiter #(
   parameter int AW      = 32,
   parameter int DW      = 32,
   parameter int TIMEOUT = 255
) (
   input  logic         clock,
   input  logic         reset,
   mem_arbiter_if.slave bus
);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
   typedef enum logic {SRC_IFU = 1'b0, SRC_LSU = 1'b1} src_t;

   localparam int            CW  = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] TMO = CW'(TIMEOUT);

   state_t        state_reg, state_next;
   src_t          owner_reg, owner_next;
   src_t          last_grant_reg, last_grant_next;
   logic [CW-1:0] cnt_reg, cnt_next;
   logic [AW-1:0] addr_reg, addr_next;
   logic          wen_reg, wen_next;
   logic [DW-1:0] wdata_reg, wdata_next;
   logic [7:0]    wmask_reg, wmask_next;
   logic          mem_valid_reg, mem_valid_next;
   logic [1:0]    resp_valid_reg, resp_valid_next;
   logic [1:0]    resp_err_reg, resp_err_next;
   logic [DW-1:0] resp_data_reg [2];
   logic [DW-1:0] resp_data_next [2];

   logic grant_ifu, grant_lsu;

   // Combinational grant: only in IDLE (and not while reset is held); a tie goes
   // to whichever requester was not granted last.
   always_comb begin
      grant_ifu = 1'b0;
      grant_lsu = 1'b0;
      if (state_reg == IDLE && !reset) begin
         if (bus.ifu_req_valid && bus.lsu_req_valid) begin
            if (last_grant_reg == SRC_LSU) grant_ifu = 1'b1;
            else                           grant_lsu = 1'b1;
         end else begin
            grant_ifu = bus.ifu_req_valid;
            grant_lsu = bus.lsu_req_valid;
         end
      end
   end

   assign bus.ifu_req_ready = grant_ifu;
   assign bus.lsu_req_ready = grant_lsu;

   // Next-state and next-output logic; everything holds unless a transition says otherwise.
   always_comb begin
      state_next      = state_reg;
      owner_next      = owner_reg;
      last_grant_next = last_grant_reg;
      cnt_next        = cnt_reg;
      addr_next       = addr_reg;
      wen_next        = wen_reg;
      wdata_next      = wdata_reg;
      wmask_next      = wmask_reg;
      mem_valid_next  = mem_valid_reg;
      resp_valid_next = '0;
      resp_err_next   = '0;
      resp_data_next  = resp_data_reg;

      case (state_reg)
         IDLE: begin
            if (grant_ifu) begin
               owner_next      = SRC_IFU;
               last_grant_next = SRC_IFU;
               addr_next       = bus.ifu_addr;
               wen_next        = 1'b0;
               wdata_next      = '0;
               wmask_next      = 8'h0F;
               mem_valid_next  = 1'b1;
               state_next      = ISSUE;
            end else if (grant_lsu) begin
               owner_next      = SRC_LSU;
               last_grant_next = SRC_LSU;
               addr_next       = bus.lsu_addr;
               wen_next        = bus.lsu_wen;
               wdata_next      = bus.lsu_wdata;
               wmask_next      = bus.lsu_wmask;
               mem_valid_next  = 1'b1;
               state_next      = ISSUE;
            end
         end
         ISSUE: begin
            if (bus.mem_ready) begin
               mem_valid_next = 1'b0;
               cnt_next       = '0;
               state_next     = WAIT;
            end
         end
         WAIT: begin
            // mem_rvalid also acknowledges writes; its data is passed back as-is
            if (bus.mem_rvalid) begin
               resp_valid_next[owner_reg] = 1'b1;
               resp_err_next[owner_reg]   = 1'b0;
               resp_data_next[owner_reg]  = bus.mem_rdata;
               state_next                 = RESP;
            end else if (cnt_reg == TMO) begin
               resp_valid_next[owner_reg] = 1'b1;
               resp_err_next[owner_reg]   = 1'b1;
               resp_data_next[owner_reg]  = '0;
               state_next                 = RESP;
            end else begin
               cnt_next = cnt_reg + CW'(1);
            end
         end
         RESP: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // State and output registers; reset aborts any transaction in flight.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_reg      <= IDLE;
         owner_reg      <= SRC_IFU;
         last_grant_reg <= SRC_LSU;
         cnt_reg        <= '0;
         addr_reg       <= '0;
         wen_reg        <= 1'b0;
         wdata_reg      <= '0;
         wmask_reg      <= '0;
         mem_valid_reg  <= 1'b0;
         resp_valid_reg <= '0;
         resp_err_reg   <= '0;
         for (int i = 0; i < 2; i++) resp_data_reg[i] <= '0;
      end else begin
         state_reg      <= state_next;
         owner_reg      <= owner_next;
         last_grant_reg <= last_grant_next;
         cnt_reg        <= cnt_next;
         addr_reg       <= addr_next;
         wen_reg        <= wen_next;
         wdata_reg      <= wdata_next;
         wmask_reg      <= wmask_next;
         mem_valid_reg  <= mem_valid_next;
         resp_valid_reg <= resp_valid_next;
         resp_err_reg   <= resp_err_next;
         for (int i = 0; i < 2; i++) resp_data_reg[i] <= resp_data_next[i];
      end
   end

   assign bus.mem_valid      = mem_valid_reg;
   assign bus.mem_wen        = wen_reg;
   assign bus.mem_raddr      = addr_reg;
   assign bus.mem_waddr      = addr_reg;
   assign bus.mem_wdata      = wdata_reg;
   assign bus.mem_wmask      = wmask_reg;

   assign bus.ifu_resp_valid = resp_valid_reg[SRC_IFU];
   assign bus.ifu_resp_err   = resp_err_reg[SRC_IFU];
   assign bus.ifu_resp_data  = resp_data_reg[SRC_IFU];
   assign bus.lsu_resp_valid = resp_valid_reg[SRC_LSU];
   assign bus.lsu_resp_err   = resp_err_reg[SRC_LSU];
   assign bus.lsu_resp_data  = resp_data_reg[SRC_LSU];

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench for mem_arbiter. A transaction-level model tracks the one
// request in flight by cycle timestamps (handshake, memory accept, first wait
// cycle, response cycle) and predicts every output cycle by cycle.
module tb_mem_arbiter;

   localparam int TMO = 4;
   localparam int NCYC = 3200;

   logic clock;
   logic reset;

   mem_arbiter_if #(.AW(32), .DW(32)) bus ();

   mem_arbiter #(.AW(32), .DW(32), .TIMEOUT(TMO)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
      end
   endtask

   // model of the transaction in flight
   bit          m_busy, m_acc, m_dec;
   int          m_own;          // 0 = IFU, 1 = LSU
   int          m_last;
   int          m_twait0, m_tresp;
   logic [31:0] m_addr, m_wdata, m_rdata;
   logic        m_wen, m_rerr;
   logic [7:0]  m_wmask;

   // requester-side held requests
   bit          ifu_pend, lsu_pend;
   logic [31:0] ifu_a, lsu_a, lsu_d;
   logic        lsu_w;
   logic [7:0]  lsu_m;

   bit after_reset, did_wait_reset, rst_drv, g_ifu, g_lsu;
   int p_req, p_ready, p_rvalid, seg;

   task automatic check_zero_state(input string pfx);
      check_eq({pfx, "_mem_valid"}, bus.mem_valid, 0);
      check_eq({pfx, "_mem_wen"}, bus.mem_wen, 0);
      check_eq({pfx, "_mem_raddr"}, bus.mem_raddr, 0);
      check_eq({pfx, "_mem_waddr"}, bus.mem_waddr, 0);
      check_eq({pfx, "_mem_wdata"}, bus.mem_wdata, 0);
      check_eq({pfx, "_mem_wmask"}, bus.mem_wmask, 0);
      check_eq({pfx, "_ifu_rv"}, bus.ifu_resp_valid, 0);
      check_eq({pfx, "_ifu_err"}, bus.ifu_resp_err, 0);
      check_eq({pfx, "_ifu_data"}, bus.ifu_resp_data, 0);
      check_eq({pfx, "_lsu_rv"}, bus.lsu_resp_valid, 0);
      check_eq({pfx, "_lsu_err"}, bus.lsu_resp_err, 0);
      check_eq({pfx, "_lsu_data"}, bus.lsu_resp_data, 0);
   endtask

   initial begin
      reset             = 1'b1;
      bus.ifu_req_valid = 1'b1;
      bus.ifu_addr      = 32'h8000_0000;
      bus.lsu_req_valid = 1'b1;
      bus.lsu_addr      = 32'h8000_1000;
      bus.lsu_wen       = 1'b1;
      bus.lsu_wdata     = 32'hDEAD_BEEF;
      bus.lsu_wmask     = 8'h0F;
      bus.mem_ready     = 1'b1;
      bus.mem_rvalid    = 1'b1;
      bus.mem_rdata     = 32'h0000_0413;

      repeat (2) @(posedge clock);
      #1;
      check_zero_state("reset");
      check_eq("reset_ifu_ready", bus.ifu_req_ready, 0);
      check_eq("reset_lsu_ready", bus.lsu_req_ready, 0);

      m_busy = 0; m_acc = 0; m_dec = 0; m_last = 1; m_own = 0;
      ifu_pend = 0; lsu_pend = 0;
      after_reset = 1; did_wait_reset = 0;

      for (int n = 0; n < NCYC; n++) begin
         @(posedge clock);
         #1;
         cyc++;

         // registered outputs for this cycle
         if (after_reset) check_zero_state("post_reset");
         check_eq("mem_valid", bus.mem_valid, m_busy && !m_acc);
         if (m_busy && !m_acc) begin
            check_eq("mem_raddr", bus.mem_raddr, m_addr);
            check_eq("mem_waddr", bus.mem_waddr, m_addr);
            check_eq("mem_wen", bus.mem_wen, m_wen);
            check_eq("mem_wdata", bus.mem_wdata, m_wdata);
            check_eq("mem_wmask", bus.mem_wmask, m_wmask);
         end
         check_eq("ifu_resp_valid", bus.ifu_resp_valid, m_busy && m_dec && cyc == m_tresp && m_own == 0);
         check_eq("lsu_resp_valid", bus.lsu_resp_valid, m_busy && m_dec && cyc == m_tresp && m_own == 1);
         if (m_busy && m_dec && cyc == m_tresp) begin
            if (m_own == 0) begin
               check_eq("ifu_resp_data", bus.ifu_resp_data, m_rdata);
               check_eq("ifu_resp_err", bus.ifu_resp_err, m_rerr);
            end else begin
               check_eq("lsu_resp_data", bus.lsu_resp_data, m_rdata);
               check_eq("lsu_resp_err", bus.lsu_resp_err, m_rerr);
            end
            $display("resp cyc=%0d owner=%s data=%h err=%0d", cyc, (m_own == 0) ? "ifu" : "lsu", m_rdata, m_rerr);
         end

         // stimulus profile: normal, contention at full speed, timeouts, heavy stalls
         seg = (n / 400) % 4;
         case (seg)
            0:       begin p_req = 50;  p_ready = 60;  p_rvalid = 50;  end
            1:       begin p_req = 100; p_ready = 100; p_rvalid = 100; end
            2:       begin p_req = 60;  p_ready = 70;  p_rvalid = 8;   end
            default: begin p_req = 40;  p_ready = 25;  p_rvalid = 20;  end
         endcase

         rst_drv = ($urandom_range(0, 99) == 0);
         if (seg == 2 && !did_wait_reset && m_busy && m_acc && !m_dec) begin
            rst_drv = 1;
            did_wait_reset = 1;
         end

         if (!ifu_pend && $urandom_range(0, 99) < p_req) begin
            ifu_pend = 1;
            ifu_a    = $urandom;
         end
         if (!lsu_pend && $urandom_range(0, 99) < p_req) begin
            lsu_pend = 1;
            lsu_a    = $urandom;
            lsu_w    = 1'($urandom_range(0, 1));
            lsu_d    = $urandom;
            lsu_m    = 8'($urandom);
         end

         reset             = rst_drv;
         bus.ifu_req_valid = ifu_pend;
         bus.ifu_addr      = ifu_a;
         bus.lsu_req_valid = lsu_pend;
         bus.lsu_addr      = lsu_a;
         bus.lsu_wen       = lsu_w;
         bus.lsu_wdata     = lsu_d;
         bus.lsu_wmask     = lsu_m;
         bus.mem_ready     = ($urandom_range(0, 99) < p_ready);
         bus.mem_rvalid    = ($urandom_range(0, 99) < p_rvalid);
         bus.mem_rdata     = $urandom;
         #1;

         // expected grant: idle only, tie goes to the requester not granted last
         g_ifu = !rst_drv && !m_busy && ifu_pend && (!lsu_pend || m_last == 1);
         g_lsu = !rst_drv && !m_busy && lsu_pend && (!ifu_pend || m_last == 0);
         check_eq("ifu_req_ready", bus.ifu_req_ready, g_ifu);
         check_eq("lsu_req_ready", bus.lsu_req_ready, g_lsu);

         // advance the model with what the DUT samples at the next edge
         if (rst_drv) begin
            m_busy = 0; m_acc = 0; m_dec = 0; m_last = 1;
            after_reset = 1;
            $display("reset cyc=%0d", cyc);
         end else begin
            after_reset = 0;
            if (m_busy && m_dec) begin
               if (cyc == m_tresp) m_busy = 0;
            end else if (m_busy && m_acc) begin
               if (bus.mem_rvalid) begin
                  m_dec = 1; m_tresp = cyc + 1; m_rdata = bus.mem_rdata; m_rerr = 0;
               end else if (cyc - m_twait0 == TMO) begin
                  m_dec = 1; m_tresp = cyc + 1; m_rdata = 0; m_rerr = 1;
               end
            end else if (m_busy) begin
               if (bus.mem_ready) begin
                  m_acc = 1; m_twait0 = cyc + 1;
               end
            end else if (g_ifu) begin
               m_busy = 1; m_acc = 0; m_dec = 0; m_own = 0; m_last = 0;
               m_addr = ifu_a; m_wen = 0; m_wdata = 0; m_wmask = 8'h0F;
               ifu_pend = 0;
               $display("grant cyc=%0d ifu addr=%h", cyc, m_addr);
            end else if (g_lsu) begin
               m_busy = 1; m_acc = 0; m_dec = 0; m_own = 1; m_last = 1;
               m_addr = lsu_a; m_wen = lsu_w; m_wdata = lsu_d; m_wmask = lsu_m;
               lsu_pend = 0;
               $display("grant cyc=%0d lsu addr=%h wen=%0d wdata=%h wmask=%h", cyc, m_addr, m_wen, m_wdata, m_wmask);
            end
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
